// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. load/store) onto one shared memory port.
// Latency: grant cycle -> mem_req from next cycle until mem_ack -> valid pulse the cycle after mem_ack.
// Backpressure: each requester stalls (stall_F/stall_M) until its valid; memory may hold off mem_ack indefinitely.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   if_req/if_addr               fetch request and address (sampled only in IDLE)
//   if_gnt/if_valid/if_rdata     fetch grant pulse, completion pulse, returned instruction
//   d_req/d_we/d_addr/d_wdata    load/store request and attributes (sampled only in IDLE)
//   d_gnt/d_valid/d_rdata        data grant pulse, completion pulse, load data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_rdata/mem_ack  shared memory port; mem_ack is a one-cycle completion pulse
//   stall_F/stall_M              combinational stall requests to the pipeline
//   err                          sticky flag: mem_ack seen while no access was outstanding
//
// Build option: define ARB_FAIR_EN to add the fetch anti-starvation counter; without it
// data requests always win a tie.

module mem_arbiter #(
    parameter int DATA_32_W  = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 if_req,
    input  logic [DATA_32_W-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_valid,
    output logic [DATA_32_W-1:0] if_rdata,

    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [DATA_32_W-1:0] d_addr,
    input  logic [DATA_32_W-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_valid,
    output logic [DATA_32_W-1:0] d_rdata,

    output logic                 mem_req,
    output logic                 mem_we,
    output logic [DATA_32_W-1:0] mem_addr,
    output logic [DATA_32_W-1:0] mem_wdata,
    input  logic [DATA_32_W-1:0] mem_rdata,
    input  logic                 mem_ack,

    output logic                 stall_F,
    output logic                 stall_M,
    output logic                 err
);

    // The fairness counter is 3 bits wide, so a threshold above 7 could never be reached.
    if (STARVE_MAX < 0 || STARVE_MAX > 7) begin : g_starve_max_range
        $error("mem_arbiter: STARVE_MAX must be within 0..7");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } state_t;

    state_t               state_q;
    logic [DATA_32_W-1:0] addr_q;
    logic [DATA_32_W-1:0] wdata_q;
    logic                 we_q;
    logic                 mem_req_q;
    logic                 if_valid_q;
    logic                 d_valid_q;
    logic [DATA_32_W-1:0] if_rdata_q;
    logic [DATA_32_W-1:0] d_rdata_q;
    logic                 err_q;

    logic                 grant_i;
    logic                 grant_d;
    logic                 pick_i;   // on a tie, hand the port to fetch instead of data

`ifdef ARB_FAIR_EN
    localparam logic [2:0] STARVE_CNT = 3'(STARVE_MAX);

    // Counts data grants that overtook a waiting fetch; any fetch grant resets it.
    logic [2:0] fair_cnt_q;

    assign pick_i = (fair_cnt_q == STARVE_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            fair_cnt_q <= 3'd0;
        end else if (grant_i) begin
            fair_cnt_q <= 3'd0;
        end else if (grant_d && if_req) begin
            fair_cnt_q <= fair_cnt_q + 3'd1;
        end
    end
`else
    assign pick_i = 1'b0;
`endif

    // Grants are decided combinationally in IDLE so the grant cycle is the cycle the request
    // is seen; the access registers load at the end of that cycle. This also lets a new grant
    // issue in the valid cycle, which is an IDLE cycle.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst && state_q == IDLE) begin
            if (d_req && if_req) begin
                grant_i = pick_i;
                grant_d = !pick_i;
            end else begin
                grant_i = if_req;
                grant_d = d_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // An access in flight is simply dropped; its late mem_ack will land in IDLE.
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            mem_req_q  <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Nothing is outstanding, so an ack here is a protocol violation and
                    // its data is not forwarded anywhere.
                    if (mem_ack) begin
                        err_q <= 1'b1;
                    end
                    if (grant_d) begin
                        addr_q    <= d_addr;
                        we_q      <= d_we;
                        wdata_q   <= d_wdata;
                        mem_req_q <= 1'b1;
                        state_q   <= BUSY_D;
                    end else if (grant_i) begin
                        addr_q    <= if_addr;
                        we_q      <= 1'b0;
                        wdata_q   <= '0;
                        mem_req_q <= 1'b1;
                        state_q   <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        if_rdata_q <= mem_rdata;
                        if_valid_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        // A store completes without touching the last load value.
                        if (!we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                        d_valid_q <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = grant_i;
    assign d_gnt     = grant_d;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    assign mem_req   = mem_req_q;
    // we_q keeps the last store's value between accesses; only present it while an access runs.
    assign mem_we    = mem_req_q & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign stall_F   = if_req & ~if_valid_q;
    assign stall_M   = d_req & ~d_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int W      = 32;
    localparam int STARVE = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req, if_gnt, if_valid;
    logic [W-1:0] if_addr, if_rdata;
    logic         d_req, d_we, d_gnt, d_valid;
    logic [W-1:0] d_addr, d_wdata, d_rdata;
    logic         mem_req, mem_we, mem_ack;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         stall_F, stall_M, err;

    int nvec  = 0;
    int nfail = 0;
    logic [W-1:0] d_last;   // last load value returned, for the store test

    mem_arbiter #(.DATA_32_W(W), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_F(stall_F), .stall_M(stall_M), .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, outputs are checked at posedge+2.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        if_req = 1'b1; d_req = 1'b1;
        step(); step(); #1;
        nvec++;
        if ({if_gnt, d_gnt} !== 2'b00) begin
            nfail++; $display("FAIL reset_gnt: got %b expected 00", {if_gnt, d_gnt});
        end
        nvec++;
        if ({mem_req, mem_we, if_valid, d_valid, err} !== 5'b0) begin
            nfail++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, if_valid, d_valid, err});
        end
        nvec++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin
            nfail++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        step(); #1;
        nvec++;
        if (mem_req !== 1'b0) begin
            nfail++; $display("FAIL reset_release_mem_req: got %b expected 0", mem_req);
        end
    endtask

    task automatic test_fetch;
        logic [W-1:0] rd;
        rd = $urandom;
        step();
        if_req = 1'b1; if_addr = 32'h0040_0000;
        #1;
        nvec++;
        if ({if_gnt, d_gnt, stall_F} !== 3'b101) begin
            nfail++; $display("FAIL fetch_gnt: got %b expected 101", {if_gnt, d_gnt, stall_F});
        end
        mem_rdata = rd;
        for (int c = 0; c < 3; c++) begin
            step();
            mem_ack = (c == 2);
            #1;
            nvec++;
            if ({mem_req, mem_we, if_gnt, if_valid} !== 4'b1000) begin
                nfail++; $display("FAIL fetch_busy_ctrl c=%0d: got %b expected 1000", c, {mem_req, mem_we, if_gnt, if_valid});
            end
            nvec++;
            if ({mem_addr, mem_wdata} !== {32'h0040_0000, 32'h0}) begin
                nfail++; $display("FAIL fetch_busy_bus c=%0d: got %h expected 0040000000000000", c, {mem_addr, mem_wdata});
            end
        end
        step();
        mem_ack = 1'b0;
        #1;
        nvec++;
        if ({if_valid, d_valid, mem_req, stall_F} !== 4'b1000 || if_rdata !== rd) begin
            nfail++; $display("FAIL fetch_valid: got %b/%h expected 1000/%h", {if_valid, d_valid, mem_req, stall_F}, if_rdata, rd);
        end
        if_req = 1'b0;
        step(); #1;
        nvec++;
        if (if_valid !== 1'b0 || if_rdata !== rd) begin
            nfail++; $display("FAIL fetch_hold: got %b/%h expected 0/%h", if_valid, if_rdata, rd);
        end
    endtask

    task automatic test_priority;
        logic [W-1:0] rd, rd2;
        rd = $urandom; rd2 = $urandom;
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0004;
        if_req = 1'b1; if_addr = 32'h0040_0004;
        #1;
        nvec++;
        if ({d_gnt, if_gnt, stall_F, stall_M} !== 4'b1011) begin
            nfail++; $display("FAIL prio_first_gnt: got %b expected 1011", {d_gnt, if_gnt, stall_F, stall_M});
        end
        step();
        mem_ack = 1'b1; mem_rdata = rd;
        #1;
        nvec++;
        if ({mem_req, mem_we, d_gnt, if_gnt, stall_F} !== 5'b10001 || mem_addr !== 32'h1000_0004) begin
            nfail++; $display("FAIL prio_busy_d: got %b/%h expected 10001/10000004", {mem_req, mem_we, d_gnt, if_gnt, stall_F}, mem_addr);
        end
        step();
        mem_ack = 1'b0; d_req = 1'b0;   // the single load is done once its data returns
        #1;
        nvec++;
        if ({d_valid, if_valid, if_gnt, d_gnt, stall_F} !== 5'b10101 || d_rdata !== rd) begin
            nfail++; $display("FAIL prio_dvalid_fetch_gnt: got %b/%h expected 10101/%h", {d_valid, if_valid, if_gnt, d_gnt, stall_F}, d_rdata, rd);
        end
        step();
        mem_ack = 1'b1; mem_rdata = rd2;
        #1;
        nvec++;
        if ({mem_req, mem_we, stall_F} !== 3'b101 || mem_addr !== 32'h0040_0004) begin
            nfail++; $display("FAIL prio_busy_i: got %b/%h expected 101/00400004", {mem_req, mem_we, stall_F}, mem_addr);
        end
        step();
        mem_ack = 1'b0;
        #1;
        nvec++;
        if ({if_valid, d_valid, stall_F} !== 3'b100 || if_rdata !== rd2) begin
            nfail++; $display("FAIL prio_ivalid: got %b/%h expected 100/%h", {if_valid, d_valid, stall_F}, if_rdata, rd2);
        end
        if_req = 1'b0;
        d_last = rd;
    endtask

    task automatic test_store;
        logic [W-1:0] sa;
        sa = $urandom & 32'hFFFF_FFFC;
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = sa; d_wdata = 32'hDEAD_BEEF;
        #1;
        nvec++;
        if ({d_gnt, if_gnt} !== 2'b10) begin
            nfail++; $display("FAIL store_gnt: got %b expected 10", {d_gnt, if_gnt});
        end
        for (int c = 0; c < 3; c++) begin
            step();
            // attributes change after the grant and must not reach the memory port
            d_we = 1'b0; d_addr = $urandom; d_wdata = $urandom;
            mem_ack = (c == 2); mem_rdata = $urandom;
            #1;
            nvec++;
            if ({mem_req, mem_we} !== 2'b11 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== sa) begin
                nfail++; $display("FAIL store_busy c=%0d: got %b/%h/%h expected 11/deadbeef/%h", c, {mem_req, mem_we}, mem_wdata, mem_addr, sa);
            end
        end
        step();
        mem_ack = 1'b0;
        #1;
        nvec++;
        if (d_valid !== 1'b1 || d_rdata !== d_last) begin
            nfail++; $display("FAIL store_valid: got %b/%h expected 1/%h", d_valid, d_rdata, d_last);
        end
        d_req = 1'b0;
        step(); #1;
        nvec++;
        if ({d_valid, mem_req} !== 2'b00 || d_rdata !== d_last) begin
            nfail++; $display("FAIL store_after: got %b/%h expected 00/%h", {d_valid, mem_req}, d_rdata, d_last);
        end
    endtask

    task automatic test_fairness;
        logic [5:0] got, exp;   // bit n = 1 when grant n went to fetch
        int ng;
`ifdef ARB_FAIR_EN
        exp = 6'b010000;
`else
        exp = 6'b000000;
`endif
        got = '0; ng = 0;
        do_reset();
        if_req = 1'b1; if_addr = $urandom;
        d_req = 1'b1; d_we = 1'b0; d_addr = $urandom;
        for (int c = 0; c < 80 && ng < 6; c++) begin
            step();
            mem_ack = mem_req; mem_rdata = $urandom;
            #1;
            nvec++;
            if (if_gnt && d_gnt) begin
                nfail++; $display("FAIL fair_dual_gnt c=%0d: got 11 expected one-hot", c);
            end
            if (if_gnt || d_gnt) begin
                got[ng] = if_gnt;
                ng++;
            end
        end
        nvec++;
        if (ng != 6) begin
            nfail++; $display("FAIL fair_grant_count: got %0d expected 6", ng);
        end
        nvec++;
        if (got !== exp) begin
            nfail++; $display("FAIL fair_order: got %b expected %b (bit0 first, 1=fetch)", got, exp);
        end
        step();
        if_req = 1'b0; d_req = 1'b0; mem_ack = mem_req;
        step();
        mem_ack = mem_req;
        step();
        mem_ack = 1'b0;
    endtask

    // Transaction-level reference: one access at a time, data wins ties unless fetch has
    // been overtaken STARVE times, each result appears the cycle after its ack.
    task automatic test_random;
        logic         i_pend, d_pend, ig, dg, m_busy, m_who, m_we, ack, eg_i, eg_d;
        logic [1:0]   m_vld, ev;
        logic [W-1:0] ci_addr, cd_addr, cd_wdata, m_addr, m_wdata, e_if, e_d;
        logic         cd_we;
        int           m_cnt;
        i_pend = 0; d_pend = 0; ig = 0; dg = 0; m_busy = 0; m_who = 0; m_we = 0;
        m_vld = 0; m_cnt = 0; e_if = '0; e_d = '0; m_addr = '0; m_wdata = '0;
        ci_addr = '0; cd_addr = '0; cd_wdata = '0; cd_we = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            ev = m_vld;
            if (ev[0]) begin i_pend = 0; ig = 0; end
            if (ev[1]) begin d_pend = 0; dg = 0; end
            if (!i_pend && ($urandom % 3 == 0)) begin
                i_pend = 1; ci_addr = $urandom;
            end
            if (!d_pend && ($urandom % 3 == 0)) begin
                d_pend = 1; cd_we = $urandom; cd_addr = $urandom; cd_wdata = $urandom;
            end
            if_req  = ig ? ($urandom % 4 != 0) : i_pend;
            if_addr = ig ? $urandom : ci_addr;
            d_req   = dg ? ($urandom % 4 != 0) : d_pend;
            d_we    = dg ? $urandom : cd_we;
            d_addr  = dg ? $urandom : cd_addr;
            d_wdata = dg ? $urandom : cd_wdata;
            eg_i = 0; eg_d = 0;
            if (!m_busy) begin
                if (i_pend && d_pend) begin
`ifdef ARB_FAIR_EN
                    if (m_cnt == STARVE) eg_i = 1; else eg_d = 1;
`else
                    eg_d = 1;
`endif
                end else begin
                    eg_i = i_pend; eg_d = d_pend;
                end
            end
            ack = m_busy && ($urandom % 3 == 0);
            mem_ack = ack; mem_rdata = $urandom;
            #1;
            nvec++;
            if ({if_gnt, d_gnt} !== {eg_i, eg_d}) begin
                nfail++; $display("FAIL rnd_gnt c=%0d: got %b expected %b", c, {if_gnt, d_gnt}, {eg_i, eg_d});
            end
            nvec++;
            if ({if_valid, d_valid} !== {ev[0], ev[1]}) begin
                nfail++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, {if_valid, d_valid}, {ev[0], ev[1]});
            end
            nvec++;
            if (mem_req !== m_busy) begin
                nfail++; $display("FAIL rnd_mem_req c=%0d: got %b expected %b", c, mem_req, m_busy);
            end
            if (m_busy) begin
                nvec++;
                if ({mem_addr, mem_we, mem_wdata} !== {m_addr, m_we, m_wdata}) begin
                    nfail++; $display("FAIL rnd_bus c=%0d: got %h/%b/%h expected %h/%b/%h", c, mem_addr, mem_we, mem_wdata, m_addr, m_we, m_wdata);
                end
            end
            nvec++;
            if ({if_rdata, d_rdata} !== {e_if, e_d}) begin
                nfail++; $display("FAIL rnd_rdata c=%0d: got %h/%h expected %h/%h", c, if_rdata, d_rdata, e_if, e_d);
            end
            nvec++;
            if ({stall_F, stall_M, err} !== {if_req & ~ev[0], d_req & ~ev[1], 1'b0}) begin
                nfail++; $display("FAIL rnd_stall_err c=%0d: got %b expected %b", c, {stall_F, stall_M, err}, {if_req & ~ev[0], d_req & ~ev[1], 1'b0});
            end
            m_vld = 2'b00;
            if (m_busy && ack) begin
                m_busy = 0;
                if (m_who) begin
                    m_vld = 2'b10;
                    if (!m_we) e_d = mem_rdata;
                end else begin
                    m_vld = 2'b01;
                    e_if = mem_rdata;
                end
            end else if (eg_d) begin
                m_busy = 1; m_who = 1; m_addr = cd_addr; m_we = cd_we; m_wdata = cd_wdata; dg = 1;
                if (i_pend) m_cnt++;
            end else if (eg_i) begin
                m_busy = 1; m_who = 0; m_addr = ci_addr; m_we = 0; m_wdata = '0; ig = 1;
                m_cnt = 0;
            end
        end
    endtask

    task automatic test_reset_abort;
        do_reset();
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000_0000;
        #1;
        nvec++;
        if (d_gnt !== 1'b1) begin
            nfail++; $display("FAIL abort_gnt: got %b expected 1", d_gnt);
        end
        step(); #1;
        nvec++;
        if (mem_req !== 1'b1) begin
            nfail++; $display("FAIL abort_busy: got %b expected 1", mem_req);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
        #1;
        nvec++;
        if ({mem_req, d_valid, err} !== 3'b000) begin
            nfail++; $display("FAIL abort_after_rst: got %b expected 000", {mem_req, d_valid, err});
        end
        step();
        mem_ack = 1'b0;
        #1;
        nvec++;
        if ({d_valid, err, mem_req} !== 3'b010 || d_rdata !== '0) begin
            nfail++; $display("FAIL abort_late_ack: got %b/%h expected 010/0", {d_valid, err, mem_req}, d_rdata);
        end
        repeat (3) step();
        #1;
        nvec++;
        if (err !== 1'b1) begin
            nfail++; $display("FAIL abort_err_sticky: got %b expected 1", err);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        nvec++;
        if (err !== 1'b0) begin
            nfail++; $display("FAIL abort_err_clear: got %b expected 0", err);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_fairness();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants tolerated while fetch waits (used only with ARB_FAIR_EN).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have ports if_req in 1 (fetch request) and if_addr in DATA_32_W (fetch address).
REQ-005 SHALL have ports if_gnt out 1 (fetch granted), if_valid out 1 (fetch done) and if_rdata out DATA_32_W (fetched instruction).
REQ-006 SHALL have ports d_req in 1 (load/store request), d_we in 1 (1=store, from MemWrite), d_addr in DATA_32_W and d_wdata in DATA_32_W.
REQ-007 SHALL have ports d_gnt out 1, d_valid out 1 and d_rdata out DATA_32_W (load data).
REQ-008 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out DATA_32_W and mem_wdata out DATA_32_W (shared memory port).
REQ-009 SHALL have ports mem_rdata in DATA_32_W and mem_ack in 1 (access complete, one-cycle pulse).
REQ-010 SHALL have ports stall_F out 1, stall_M out 1 and err out 1 (sticky protocol error).

Function
REQ-011 SHALL implement states IDLE, BUSY_I and BUSY_D.
REQ-012 IDLE: on d_req, SHALL pulse d_gnt and go to BUSY_D; on if_req only, SHALL pulse if_gnt and go to BUSY_I; if both, SHALL grant data (REQ-026 excepted).
REQ-013 On grant, SHALL register address, we and wdata; mem_req, mem_addr, mem_we and mem_wdata SHALL be driven from these registers starting the next cycle.
REQ-014 For a fetch, mem_we SHALL be 0 and mem_wdata SHALL be 0.
REQ-015 BUSY_*: mem_req=1 and mem_addr/mem_we/mem_wdata SHALL stay stable until the mem_ack cycle.
REQ-016 On mem_ack in BUSY_*, SHALL return to IDLE, capture mem_rdata and pulse the matching valid for one cycle in the next cycle; the matching rdata SHALL change only then and hold until the next valid.
REQ-017 A store completion SHALL pulse d_valid and SHALL leave d_rdata unchanged.
REQ-018 Minimum access SHALL take 3 cycles (grant, mem_req with ack, valid); a new grant MAY issue in the valid cycle.
REQ-019 Requests and attributes SHALL be sampled only in IDLE; a request dropped before grant SHALL be discarded; req changes after grant SHALL be ignored until valid.
REQ-020 stall_F SHALL equal if_req & ~if_valid (combinational); stall_M SHALL equal d_req & ~d_valid.
REQ-021 Gnt and valid SHALL never be asserted for both requesters in the same cycle.
REQ-022 mem_ack in IDLE SHALL be ignored for data and SHALL set err; err SHALL clear only on rst.
REQ-023 There SHALL be no timeout: BUSY_* SHALL wait indefinitely for mem_ack.

Reset
REQ-024 On rst at a clock edge, SHALL go to IDLE; mem_req, mem_we, gnts, valids and err SHALL be 0; address/data/rdata registers SHALL be 0; the fairness counter SHALL be 0.
REQ-025 rst during BUSY_* SHALL abort the access with no valid pulse; a mem_ack arriving in the cycle after reset SHALL set err.

Configuration
REQ-026 With ARB_FAIR_EN defined, a 3-bit counter SHALL increment on each data grant made while if_req=1 and SHALL clear on any fetch grant; when it equals STARVE_MAX and both requests are present in IDLE, fetch SHALL be granted.
REQ-027 Without ARB_FAIR_EN, the counter SHALL be absent and strict data priority SHALL always apply.

Verification
REQ-028 Fetch only, if_addr=0x0040_0000, ack 2 cycles after mem_req -> if_gnt pulse, mem_addr=0x0040_0000 and mem_we=0, if_valid one cycle after ack with if_rdata=mem_rdata.
REQ-029 Simultaneous requests, d_addr=0x1000_0004 as a load -> d_gnt first with if_gnt 0; fetch granted in the d_valid cycle; stall_F=1 throughout.
REQ-030 Store d_we=1, d_wdata=0xDEAD_BEEF -> mem_we=1 and mem_wdata=0xDEAD_BEEF stable until ack, d_valid pulse, d_rdata unchanged.
REQ-031 Both requests held for 6 accesses, ARB_FAIR_EN defined, STARVE_MAX=4 -> grant order D,D,D,D,I,D; without ARB_FAIR_EN -> D,D,D,D,D,D.
REQ-032 rst asserted in BUSY_D then ack in the following cycle -> IDLE, no d_valid, err=1 until next rst.
